// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types, defaults and helpers for the seven-segment
//                display scanner and its sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Default number of display digits.
    localparam int DEFAULT_DIGITS = 4;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // Converter state encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Largest value representable on the display: 10**digits - 1.
    // Bounded loop so it stays a legal constant function for up to 8 digits.
    function automatic int unsigned max_value(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(digits)) begin
                v = v * 10;
            end
        end
        return v - 1;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter with a
//                valid/ready input handshake and saturation at the display
//                maximum. Produces a one-cycle done pulse when the BCD result
//                is final.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int BIN_W  = $clog2(10**DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sat,
    output logic                  done
);

    localparam int               BCD_W   = 4 * DIGITS;
    localparam int               CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_value(DIGITS));
    localparam logic [CNT_W-1:0] LAST_SH = CNT_W'(BIN_W - 1);

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic               sat_q,   sat_d;

    logic [BCD_W-1:0]   w_adj;
    bcd_t               w_nib;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        w_adj = '0;
        w_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib = bcd_q[4*i +: 4];
            w_adj[4*i +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    end

    // Converter next-state: accept/saturate in IDLE, shift BIN_W times, commit.
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        sh_cnt_d = sh_cnt_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_value > MAX_VAL) begin
                        bin_d = MAX_VAL;
                        sat_d = 1'b1;
                    end else begin
                        bin_d = in_value;
                        sat_d = 1'b0;
                    end
                    bcd_d    = '0;
                    sh_cnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // The adjusted MSB is always zero because the value is bounded.
                {bcd_d, bin_d} = {w_adj[BCD_W-2:0], bin_q, 1'b0};
                sh_cnt_d       = sh_cnt_q + 1'b1;
                if (sh_cnt_q == LAST_SH) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter state registers; reset discards any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            sh_cnt_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            sh_cnt_q <= sh_cnt_d;
            sat_q    <= sat_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = (state_q == COMMIT);
    assign bcd      = bcd_q;
    assign sat      = sat_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scanner
//  Description : Converts an accepted binary value to BCD, holds it in a
//                display register and time-multiplexes the digits onto a
//                shared digit bus with an active-low one-hot anode select.
//                Optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter  int DIGITS      = DEFAULT_DIGITS,
    parameter  int REFRESH_DIV = 100000,
    parameter  int LZ_BLANK    = 1,
    localparam int BIN_W       = $clog2(10**DIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   in_value,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               overflow,
    output logic [3:0]         digit,
    output logic [DIGITS-1:0]  an
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam int                CNT_W     = $clog2(REFRESH_DIV);
    localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    // Mask of an all-zero display: every slot above digit 0 blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = (LZ_BLANK != 0) ? ~DIGITS'(1) : '0;

    logic [BCD_W-1:0]   w_bcd;
    logic               w_sat;
    logic               w_done;
    logic [DIGITS-1:0]  w_blank;
    logic               w_zero_run;

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [BCD_W-1:0]   disp_q,  disp_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               ovf_q,   ovf_d;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd      (w_bcd),
        .sat      (w_sat),
        .done     (w_done)
    );

    // Leading-zero mask of the fresh result: slot i>0 blanks when it and all above are zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run && (w_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = (LZ_BLANK != 0) && w_zero_run;
        end
    end

    // Next-state for the free-running prescaler/scan index and the atomic display commit.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        disp_d  = disp_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + 1'b1);
        end
        if (w_done) begin
            disp_d  = w_bcd;
            blank_d = w_blank;
            ovf_d   = w_sat;
        end
    end

    // Scanner and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output mux: current slot's digit and its anode, suppressed when blanked.
    always_comb begin
        digit = '0;
        an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit = disp_q[4*i +: 4];
                an[i] = blank_q[i];
            end
        end
    end

    assign overflow = ovf_q;

endmodule : seg_display_scanner
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scanner
//  Description : Directed self-checking bench for seg_display_scanner
//                (DIGITS=4, REFRESH_DIV=4), with a second instance that has
//                leading-zero blanking disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic        clk;
    logic        rst;
    logic [13:0] in_value;
    logic        in_valid;
    logic        in_ready,  in_ready_nb;
    logic        overflow,  overflow_nb;
    logic [3:0]  digit,     digit_nb;
    logic [3:0]  an,        an_nb;

    int          compared;
    int          mismatched;
    int unsigned cyc;        // non-reset edges since the last reset edge
    logic [15:0] exp_disp;   // expected display contents in BCD
    logic        exp_ovf;

    seg_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .LZ_BLANK    (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .overflow (overflow),
        .digit    (digit),
        .an       (an)
    );

    seg_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .LZ_BLANK    (0)
    ) u_dut_nb (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready_nb),
        .overflow (overflow_nb),
        .digit    (digit_nb),
        .an       (an_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan slot expected from the number of edges since reset.
    function automatic int exp_idx();
        return int'((cyc / REFRESH_DIV) % DIGITS);
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] d, input int i);
        logic [15:0] t;
        t = d >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [3:0] exp_an(input logic [15:0] d, input int i, input bit lz);
        logic [3:0] one;
        one = 4'b0001;
        if (lz && i > 0 && (d >> (4 * i)) == 16'h0) return 4'b1111;
        return ~(one << i);
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        #1;
    endtask

    task automatic accept(input logic [13:0] v);
        in_value = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_value = '0;
        tick(); tick();
        rst = 1'b0;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        compared++; if (digit !== 4'd0) begin mismatched++; $display("FAIL rst_digit: got %h want 0", digit); end
        compared++; if (an !== 4'b1110) begin mismatched++; $display("FAIL rst_an: got %b want 1110", an); end
        exp_disp = 16'h0000; exp_ovf = 1'b0;
        for (int k = 0; k < 16; k++) begin
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL rst_scan_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            compared++; if (digit !== 4'd0) begin mismatched++; $display("FAIL rst_scan_digit cyc%0d: got %h want 0", cyc, digit); end
            tick();
        end
    endtask

    task automatic test_load_1234();
        logic [15:0] old;
        old = exp_disp;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL l1234_pre_ready: got %b want 1", in_ready); end
        accept(14'd1234);
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL l1234_busy_T: got %b want 0", in_ready); end
        for (int k = 1; k < 15; k++) begin
            tick();
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL l1234_busy +%0d: got %b want 0", k, in_ready); end
            compared++; if (digit !== exp_digit(old, exp_idx())) begin mismatched++; $display("FAIL l1234_old_digit +%0d: got %h want %h", k, digit, exp_digit(old, exp_idx())); end
            compared++; if (an !== exp_an(old, exp_idx(), 1)) begin mismatched++; $display("FAIL l1234_old_an +%0d: got %b want %b", k, an, exp_an(old, exp_idx(), 1)); end
        end
        tick();
        exp_disp = 16'h1234; exp_ovf = 1'b0;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL l1234_ready_T15: got %b want 1", in_ready); end
        for (int k = 0; k < 20; k++) begin
            compared++; if (digit !== exp_digit(exp_disp, exp_idx())) begin mismatched++; $display("FAIL l1234_digit cyc%0d: got %h want %h", cyc, digit, exp_digit(exp_disp, exp_idx())); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL l1234_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            tick();
        end
    endtask

    task automatic test_blank_7();
        accept(14'd7);
        repeat (15) tick();
        exp_disp = 16'h0007;
        for (int k = 0; k < 16; k++) begin
            compared++; if (digit !== exp_digit(exp_disp, exp_idx())) begin mismatched++; $display("FAIL b7_digit cyc%0d: got %h want %h", cyc, digit, exp_digit(exp_disp, exp_idx())); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL b7_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            compared++; if (digit_nb !== exp_digit(exp_disp, exp_idx())) begin mismatched++; $display("FAIL b7_nb_digit cyc%0d: got %h want %h", cyc, digit_nb, exp_digit(exp_disp, exp_idx())); end
            compared++; if (an_nb !== exp_an(exp_disp, exp_idx(), 0)) begin mismatched++; $display("FAIL b7_nb_an cyc%0d: got %b want %b", cyc, an_nb, exp_an(exp_disp, exp_idx(), 0)); end
            tick();
        end
    endtask

    task automatic test_overflow();
        accept(14'd12000);
        repeat (14) tick();
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_before: got %b want 0", overflow); end
        tick();
        exp_disp = 16'h9999; exp_ovf = 1'b1;
        compared++; if (overflow !== exp_ovf) begin mismatched++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int k = 0; k < 16; k++) begin
            compared++; if (digit !== 4'h9) begin mismatched++; $display("FAIL ovf_digit cyc%0d: got %h want 9", cyc, digit); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL ovf_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            tick();
        end
        accept(14'd5);
        repeat (14) tick();
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_hold: got %b want 1", overflow); end
        tick();
        exp_disp = 16'h0005; exp_ovf = 1'b0;
        compared++; if (overflow !== exp_ovf) begin mismatched++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int k = 0; k < 16; k++) begin
            compared++; if (digit !== exp_digit(exp_disp, exp_idx())) begin mismatched++; $display("FAIL five_digit cyc%0d: got %h want %h", cyc, digit, exp_digit(exp_disp, exp_idx())); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL five_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        accept(14'd1234);
        tick(); tick();
        in_value = 14'd42; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 4; k < 15; k++) begin
            tick();
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL ign_busy +%0d: got %b want 0", k, in_ready); end
        end
        tick();
        exp_disp = 16'h1234;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL ign_ready_T15: got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            compared++; if (digit !== exp_digit(exp_disp, exp_idx())) begin mismatched++; $display("FAIL ign_digit cyc%0d: got %h want %h", cyc, digit, exp_digit(exp_disp, exp_idx())); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL ign_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL ign_idle cyc%0d: got %b want 1", cyc, in_ready); end
            tick();
        end
    endtask

    task automatic test_reset_midconv();
        accept(14'd12000);
        repeat (15) tick();
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL rmc_ovf_pre: got %b want 1", overflow); end
        accept(14'd1234);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_disp = 16'h0000; exp_ovf = 1'b0;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmc_ready: got %b want 1", in_ready); end
        compared++; if (digit !== 4'd0) begin mismatched++; $display("FAIL rmc_digit: got %h want 0", digit); end
        compared++; if (an !== 4'b1110) begin mismatched++; $display("FAIL rmc_an: got %b want 1110", an); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rmc_ovf: got %b want 0", overflow); end
        compared++; if (an_nb !== 4'b1110) begin mismatched++; $display("FAIL rmc_nb_an: got %b want 1110", an_nb); end
        for (int k = 0; k < 24; k++) begin
            tick();
            compared++; if (digit !== 4'd0) begin mismatched++; $display("FAIL rmc_scan_digit cyc%0d: got %h want 0", cyc, digit); end
            compared++; if (an !== exp_an(exp_disp, exp_idx(), 1)) begin mismatched++; $display("FAIL rmc_scan_an cyc%0d: got %b want %b", cyc, an, exp_an(exp_disp, exp_idx(), 1)); end
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmc_scan_ready cyc%0d: got %b want 1", cyc, in_ready); end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        exp_disp   = '0;
        exp_ovf    = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_value   = '0;
        test_reset();
        test_load_1234();
        test_blank_7();
        test_overflow();
        test_ignore_busy();
        test_reset_midconv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_seg_display_scanner
`default_nettype wire

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Upstream feeder for the per-digit seven-segment decoder.
- Accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential double-dabble converter.
- Holds the result in a display register and time-multiplexes the digits. Each scan slot presents one 4-bit digit, for the decoder to turn into segments, together with an active-low one-hot anode select.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- REFRESH_DIV, 100000, clock cycles each digit slot is held (≥2).
- LZ_BLANK, 1, 1 = blank leading zeros (digit 0 is never blanked).
- BIN_W, $clog2(10**DIGITS) (localparam, 14 for DIGITS=4), binary input width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_value  in  BIN_W  binary value to display.
- in_valid  in  1  in_value is valid.
- in_ready  out  1  converter idle; the value is accepted when in_valid && in_ready.
- overflow  out  1  last accepted value exceeded 10**DIGITS-1.
- digit  out  4  BCD digit of the current scan slot (to the decoder).
- an  out  DIGITS  anode select, active-low, one-hot or all-ones when the slot is blanked.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Converter goes to IDLE; any conversion in flight is discarded.
  - Display register cleared to all zeros; overflow=0.
  - Prescaler cnt=0; scan index idx=0.
  - Output values after reset: in_ready=1, digit=0, an={DIGITS-1 ones, 0} (e.g. 4'b1110).
- Scanner (free-running, independent of the converter):
  - Each edge: if cnt==REFRESH_DIV-1 then cnt<=0 and idx<=(idx==DIGITS-1)?0:idx+1; otherwise cnt<=cnt+1.
  - Each slot therefore lasts exactly REFRESH_DIV cycles.
  - digit and an are combinational from idx and the display register (no added latency).
  - digit = disp[idx].
  - an = ~(1<<idx), unless slot idx is blanked, in which case an = all ones. digit still drives disp[idx] while blanked.
- Blanking:
  - Applies only when LZ_BLANK=1.
  - Slot i>0 is blanked iff disp[j]==0 for all j≥i.
  - The blank mask is computed and registered at COMMIT.
- Converter FSM:
  - IDLE: in_ready=1. On in_valid:
    - latch in_value;
    - if in_value > 10**DIGITS-1, load 10**DIGITS-1 instead and set sat=1, else sat=0;
    - clear the BCD shift register and sh_cnt, then go to SHIFT.
  - SHIFT: each cycle:
    - every BCD nibble ≥5 gets +3;
    - then {bcd,bin} shifts left by 1;
    - sh_cnt++;
    - after BIN_W shifts, go to COMMIT.
  - COMMIT (1 cycle):
    - disp <= bcd and blank mask <= computed mask, all digits updated on the same edge (atomic);
    - overflow <= sat;
    - go to IDLE.
- Latency:
  - Accept edge T; display and overflow update at edge T+BIN_W+1 (T+15 for DIGITS=4).
  - in_ready is low from T+1 through T+BIN_W+1 and high again after edge T+BIN_W+1.
- in_valid while in_ready=0 is ignored. There is no queue; the upstream must hold the value until it sees in_ready.
- COMMIT coinciding with a scan advance: both take effect on the same edge, and the new slot shows the new value.
- Slot duration is unaffected by conversions. overflow holds until the next COMMIT.

Decomposition:
- Package seg_pkg: bcd_t (logic [3:0]), conv_state_t enum {IDLE, SHIFT, COMMIT}, default DIGITS constant, max_value function (10**DIGITS-1).
- Sub-module bin2bcd_seq: the handshake, saturation, the FSM and the double-dabble datapath. It outputs bcd[DIGITS], sat and a done pulse.
- The top level holds the prescaler, scan index, display register, blank mask and output muxing.

Test Plan (DIGITS=4, REFRESH_DIV=4):
1. Reset held 2 cycles, then released → in_ready=1, overflow=0, digit=0, an=1110. Holds 4 cycles, then an=1111 (leading zeros blanked) through the rest of the scan.
2. Load 1234 at edge T → in_ready=0 for 15 cycles; disp updates at T+15. Scan then shows digit 4/an=1110, 3/1101, 2/1011, 1/0111, each slot exactly 4 cycles, repeating.
3. Load 7 → slot 0 gives digit=7, an=1110; slots 1–3 give an=1111. With LZ_BLANK=0, slots 1–3 give digit=0 with their anode active.
4. Load 12000 → display 9999, overflow=1 at T+15. Then load 5 → overflow=0, display "   5".
5. Load 1234, then pulse in_valid with 42 three cycles later (in_ready=0) → ignored; display 1234 and in_ready returns high at T+15.
6. Load 1234, assert rst at T+5 → next cycle: in_ready=1, digit=0, an=1110, overflow=0; 1234 never appears.
